// File: rtl/fetch_line_responder_if.sv
// Fetch-stage line-fill handshake between a requester (master) and the
// line responder (slave).
//   i_wb_req        requester -> responder, held until o_wb_ready
//   i_wb_address    requester -> responder, line-fill byte address
//   o_wb_ready      responder -> requester, one-cycle data-valid pulse
//   o_wb_read_data  responder -> requester, 16-byte cache line
interface fetch_line_responder_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 128;

    logic              i_wb_req;
    logic [ADDR_W-1:0] i_wb_address;
    logic              o_wb_ready;
    logic [LINE_W-1:0] o_wb_read_data;

    modport master (
        output i_wb_req,
        output i_wb_address,
        input  o_wb_ready,
        input  o_wb_read_data
    );

    modport slave (
        input  i_wb_req,
        input  i_wb_address,
        output o_wb_ready,
        output o_wb_read_data
    );
endinterface

// File: rtl/fetch_line_responder.sv
// Fetch line responder: accepts a line-fill request, waits LATENCY (+ optional
// jitter) cycles, returns a synthetic 16-byte line, then idles one gap cycle.
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous active-high reset
//   wb           line-fill handshake (slave side)
//   o_busy       high whenever the FSM is not in IDLE
//   o_req_count  saturating count of accepted requests
// Build option: define FETCH_RESP_JITTER_EN to add 0..3 cycles of LFSR-driven
// latency jitter on each request.
module fetch_line_responder #(
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] SEED    = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    fetch_line_responder_if.slave        wb,
    output logic                         o_busy,
    output logic [15:0]                  o_req_count
);
    localparam int unsigned CNT_W  = 5;   // LATENCY (<=15) + jitter (<=3)
    localparam int unsigned LADR_W = 28;
    localparam int unsigned LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [LADR_W-1:0]   line_addr;
    logic                ready_q;
    logic [LINE_W-1:0]   data_q;
    logic [CNT_W-1:0]    load_val;

    // Byte offset within the line is irrelevant to a full-line fill.
    logic unused_addr_bits;
    assign unused_addr_bits = ^wb.i_wb_address[3:0];

`ifdef FETCH_RESP_JITTER_EN
    // x^4+x^3+1 LFSR, free-running; its low two bits add jitter at acceptance.
    logic [3:0] lfsr;
    always_ff @(posedge clk) begin
        if (reset) lfsr <= 4'b1001;
        else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
    assign load_val = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
    assign load_val = CNT_W'(LATENCY);
`endif

    // Word k = {line address, k, 2'b00} ^ SEED.
    function automatic logic [LINE_W-1:0] build_line(input logic [LADR_W-1:0] la);
        logic [LINE_W-1:0] line;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            line[32*k +: 32] = {la, 2'(k), 2'b00} ^ SEED;
        end
        return line;
    endfunction

    // Request FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            line_addr   <= '0;
            ready_q     <= 1'b0;
            data_q      <= '0;
            o_busy      <= 1'b0;
            o_req_count <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb.i_wb_req) begin
                        line_addr <= wb.i_wb_address[31:4];
                        o_busy    <= 1'b1;
                        if (o_req_count != 16'hFFFF) o_req_count <= o_req_count + 16'd1;
                        if (load_val == '0) begin
                            // Zero latency: respond straight from the live address.
                            state    <= RESP;
                            ready_q  <= 1'b1;
                            data_q   <= build_line(wb.i_wb_address[31:4]);
                            wait_cnt <= '0;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= load_val;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == CNT_W'(1)) begin
                        state    <= RESP;
                        ready_q  <= 1'b1;
                        data_q   <= build_line(line_addr);
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= GAP;
                end
                GAP: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    assign wb.o_wb_ready     = ready_q;
    assign wb.o_wb_read_data = data_q;
endmodule
